// File: rtl/turbo_encoder_core_pkg.sv
// Shared definitions for the turbo encoder core: FSM state codes and
// default block/tail sizes.
package turbo_encoder_core_pkg;

  // Block-sequencing FSM states; codes are visible on current_state.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENCODE = 3'd1,
    ST_TERM   = 3'd2,
    ST_CLEAR  = 3'd3
  } state_t;

  localparam int K_SMALL_DEF     = 1056;
  localparam int K_LARGE_DEF     = 6144;
  localparam int TAIL_CYCLES_DEF = 4;
  localparam int CNT_W_DEF       = 14;

  // True in the states where incoming bits advance the encoders.
  function automatic logic accepts_data(input state_t st);
    return (st == ST_IDLE) || (st == ST_ENCODE);
  endfunction

endpackage

// File: rtl/turbo_encoder_core_rsc_enc.sv
// Recursive systematic convolutional encoder, g0 = 1+D^2+D^3 (feedback),
// g1 = 1+D+D^3 (parity). Outputs are combinational from u and the state.
module rsc_enc
  import turbo_encoder_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       enable,
  input  logic       u,
  output logic       x,
  output logic       z,
  output logic [2:0] Q
);

  logic [2:0] q_reg;
  logic       f;

  // Feedback bit and parity from current input and shift-register contents.
  always_comb begin
    f = u ^ q_reg[1] ^ q_reg[0];
    z = f ^ q_reg[2] ^ q_reg[0];
    x = u;
  end

  // Shift register: Q[2] is the newest feedback bit; clear wins over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= 3'b000;
    end else if (clr) begin
      q_reg <= 3'b000;
    end else if (enable) begin
      q_reg <= {f, q_reg[2], q_reg[1]};
    end
  end

  assign Q = q_reg;

endmodule

// File: rtl/turbo_encoder_core.sv
// Turbo encoder control/constituent core: two RSC encoders (natural and
// interleaved order), block-sequencing FSM and a delayed length flag.
module turbo_encoder_core
  import turbo_encoder_core_pkg::*;
#(
  parameter int K_SMALL     = K_SMALL_DEF,
  parameter int K_LARGE     = K_LARGE_DEF,
  parameter int TAIL_CYCLES = TAIL_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       length,
  input  logic       ck,
  input  logic       ckp,
  output logic       xk,
  output logic       zk,
  output logic       zkp,
  output logic [2:0] q,
  output logic [2:0] p,
  output logic       enc_enable,
  output logic       trellis_enable,
  output logic       switch,
  output logic       clr,
  output logic       trl_clr,
  output logic [2:0] current_state,
  output logic       length_out
);

  localparam logic [CNT_W-1:0] K_SMALL_LAST = CNT_W'(K_SMALL - 1);
  localparam logic [CNT_W-1:0] K_LARGE_LAST = CNT_W'(K_LARGE - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST    = CNT_W'(TAIL_CYCLES - 1);
  localparam logic             K_SMALL_ONE  = (K_SMALL == 1);
  localparam logic             K_LARGE_ONE  = (K_LARGE == 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             k_sel_reg;
  logic             trellis_reg;
  logic             clr_reg;
  logic             length_reg;
  logic [CNT_W-1:0] k_last;
  logic             first_is_last;

  // Last bit index of the block currently being encoded.
  always_comb begin
    k_last        = k_sel_reg ? K_LARGE_LAST : K_SMALL_LAST;
    first_is_last = length ? K_LARGE_ONE : K_SMALL_ONE;
  end

  // Encoders only move on valid bits while a block is being accepted.
  always_comb begin
    enc_enable = data_valid & accepts_data(state_reg);
  end

  // Block sequencer: IDLE -> ENCODE -> TERM (tail cycles) -> CLEAR -> IDLE.
  // The counter tracks bits in ENCODE and tail cycles in TERM; strobes are
  // registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      k_sel_reg   <= 1'b0;
      trellis_reg <= 1'b0;
      clr_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          trellis_reg <= 1'b0;
          clr_reg     <= 1'b0;
          if (data_valid) begin
            k_sel_reg <= length;
            if (first_is_last) begin
              state_reg   <= ST_TERM;
              cnt_reg     <= '0;
              trellis_reg <= 1'b1;
            end else begin
              state_reg <= ST_ENCODE;
              cnt_reg   <= CNT_W'(1);
            end
          end
        end
        ST_ENCODE: begin
          if (data_valid) begin
            if (cnt_reg == k_last) begin
              state_reg   <= ST_TERM;
              cnt_reg     <= '0;
              trellis_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        ST_TERM: begin
          if (cnt_reg == TAIL_LAST) begin
            state_reg   <= ST_CLEAR;
            cnt_reg     <= '0;
            trellis_reg <= 1'b0;
            clr_reg     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_CLEAR: begin
          state_reg <= ST_IDLE;
          clr_reg   <= 1'b0;
        end
        default: begin
          state_reg   <= ST_IDLE;
          cnt_reg     <= '0;
          trellis_reg <= 1'b0;
          clr_reg     <= 1'b0;
        end
      endcase
    end
  end

  // Length flag delayed by one cycle for the downstream logic, no enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      length_reg <= 1'b0;
    end else begin
      length_reg <= length;
    end
  end

  // Encoder 1 sees natural-order bits and provides the systematic output.
  rsc_enc u_enc1 (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_reg),
    .enable (enc_enable),
    .u      (ck),
    .x      (xk),
    .z      (zk),
    .Q      (q)
  );

  // Encoder 2 sees interleaved bits; its systematic copy is not needed.
  rsc_enc u_enc2 (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_reg),
    .enable (enc_enable),
    .u      (ckp),
    .x      (),
    .z      (zkp),
    .Q      (p)
  );

  assign trellis_enable = trellis_reg;
  assign switch         = trellis_reg;
  assign clr            = clr_reg;
  assign trl_clr        = clr_reg;
  assign current_state  = state_reg;
  assign length_out     = length_reg;

endmodule

// File: tb/tb_turbo_encoder_core.sv
// Directed bench for turbo_encoder_core with shortened blocks (K=4/6).
module tb_turbo_encoder_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_valid;
  logic       length;
  logic       ck;
  logic       ckp;
  logic       xk;
  logic       zk;
  logic       zkp;
  logic [2:0] q;
  logic [2:0] p;
  logic       enc_enable;
  logic       trellis_enable;
  logic       switch;
  logic       clr;
  logic       trl_clr;
  logic [2:0] current_state;
  logic       length_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  turbo_encoder_core #(
    .K_SMALL     (4),
    .K_LARGE     (6),
    .TAIL_CYCLES (4),
    .CNT_W       (14)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_valid     (data_valid),
    .length         (length),
    .ck             (ck),
    .ckp            (ckp),
    .xk             (xk),
    .zk             (zk),
    .zkp            (zkp),
    .q              (q),
    .p              (p),
    .enc_enable     (enc_enable),
    .trellis_enable (trellis_enable),
    .switch         (switch),
    .clr            (clr),
    .trl_clr        (trl_clr),
    .current_state  (current_state),
    .length_out     (length_out)
  );

  typedef struct {
    logic       dv;
    logic       ck;
    logic       ckp;
    logic       exp_zk;
    logic       exp_zkp;
    logic       chk_z;
    logic       exp_en;
    logic [2:0] exp_q;
    logic [2:0] exp_p;
    logic [2:0] exp_st;
    logic       exp_trl;
    logic       exp_clr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dv, input logic ln, input logic c, input logic cp);
    data_valid = dv;
    length     = ln;
    ck         = c;
    ckp        = cp;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".state"}, 32'(current_state), 32'd0);
    chk({tag, ".q"}, 32'(q), 32'd0);
    chk({tag, ".p"}, 32'(p), 32'd0);
    chk({tag, ".strobes"}, 32'({enc_enable, trellis_enable, switch, clr, trl_clr, length_out}), 32'd0);
  endtask

  int         ntrl;
  logic       saw_clr;
  logic [5:0] len_pat;

  initial begin
    // Impulse on encoder 1 ({1,0,0,0}) and {1,1,0,0} on encoder 2, K=4,
    // followed by the tail and clear cycles.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 3'b100, 3'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 3'b110, 3'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 3'b111, 3'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b110, 3'b011, 3'd2, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b011, 3'd2, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b011, 3'd2, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b011, 3'd2, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b011, 3'd3, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0};

    // Reset then idle.
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_all_zero("reset");
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all_zero($sformatf("idle%0d", i));
    end

    // Table-driven K_SMALL block.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].dv, 1'b0, vecs[i].ck, vecs[i].ckp);
      chk($sformatf("v%0d.en", i), 32'(enc_enable), 32'(vecs[i].exp_en));
      chk($sformatf("v%0d.xk", i), 32'(xk), 32'(vecs[i].ck));
      if (vecs[i].chk_z) begin
        chk($sformatf("v%0d.zk", i), 32'(zk), 32'(vecs[i].exp_zk));
        chk($sformatf("v%0d.zkp", i), 32'(zkp), 32'(vecs[i].exp_zkp));
      end
      tick();
      chk($sformatf("v%0d.q", i), 32'(q), 32'(vecs[i].exp_q));
      chk($sformatf("v%0d.p", i), 32'(p), 32'(vecs[i].exp_p));
      chk($sformatf("v%0d.state", i), 32'(current_state), 32'(vecs[i].exp_st));
      chk($sformatf("v%0d.trl", i), 32'({trellis_enable, switch}), 32'({2{vecs[i].exp_trl}}));
      chk($sformatf("v%0d.clr", i), 32'({clr, trl_clr}), 32'({2{vecs[i].exp_clr}}));
      chk($sformatf("v%0d.len_out", i), 32'(length_out), 32'd0);
    end

    // K_LARGE block: length toggles mid-block but K stays latched at 6.
    len_pat = 6'b101001;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, len_pat[i], 1'b0, 1'b0);
      tick();
      chk($sformatf("large%0d.len_out", i), 32'(length_out), 32'(len_pat[i]));
      chk($sformatf("large%0d.state", i), 32'(current_state), (i == 5) ? 32'd2 : 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ntrl = 0;
    saw_clr = 1'b0;
    for (int c = 0; c < 10 && !saw_clr; c++) begin
      if (trellis_enable) ntrl++;
      tick();
      saw_clr = clr;
    end
    chk("large.trl_cycles", 32'(ntrl), 32'd4);
    chk("large.clr_seen", 32'(saw_clr), 32'd1);
    tick();
    chk("large.end_state", 32'(current_state), 32'd0);

    // Stall: two valid bits, two idle cycles, two valid bits.
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("stall.pre_q", 32'(q), 32'b110);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("stall%0d.en", i), 32'(enc_enable), 32'd0);
      tick();
      chk($sformatf("stall%0d.q", i), 32'(q), 32'b110);
      chk($sformatf("stall%0d.p", i), 32'(p), 32'b110);
      chk($sformatf("stall%0d.state", i), 32'(current_state), 32'd1);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall.bit3_q", 32'(q), 32'b111);
    chk("stall.bit3_state", 32'(current_state), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall.bit4_q", 32'(q), 32'b011);
    chk("stall.bit4_p", 32'(p), 32'b011);
    chk("stall.bit4_state", 32'(current_state), 32'd2);

    // Asynchronous reset in the middle of TERM.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #3;
    rst = 1'b1;
    tick();
    chk("after_rst.state", 32'(current_state), 32'd0);
    chk("after_rst.q", 32'(q), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turbo_encoder_core.md
Name: turbo_encoder_core

Overview:
Control and constituent-encoding core of the LTE-style turbo encoder. It contains two identical recursive systematic convolutional (RSC) encoders: one fed with natural-order bits, one fed with interleaved bits. It also contains a block-sequencing FSM and a registered copy of the block-length flag. Its outputs (systematic/parity bits, encoder states, control strobes) feed the downstream trellis-termination and output-buffering logic.

Parameters:
K_SMALL, 1056, block length in bits when the length flag is 0
K_LARGE, 6144, block length in bits when the length flag is 1
TAIL_CYCLES, 4, number of cycles spent in TERM
CNT_W, 14, width of the bit counter; must hold K_LARGE-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
data_valid  in  1  ck/ckp carry a valid bit this cycle
length  in  1  block-length select: 1 = K_LARGE, 0 = K_SMALL
ck  in  1  natural-order input bit
ckp  in  1  interleaved input bit
xk  out  1  systematic bit; equals ck
zk  out  1  parity bit from encoder 1
zkp  out  1  parity bit from encoder 2
q  out  3  encoder-1 state {D1,D2,D3}
p  out  3  encoder-2 state {D1,D2,D3}
enc_enable  out  1  encoders advance this cycle
trellis_enable  out  1  termination phase active
switch  out  1  output mux selects termination path; equals trellis_enable
clr  out  1  encoder-state clear strobe
trl_clr  out  1  termination-logic clear strobe
current_state  out  3  FSM state code
length_out  out  1  length delayed one cycle

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counters 0, q=p=0, length_out=0, all strobes 0.
- RSC encoder, identical for both encoders:
  - State Q[2]=f(k-1), Q[1]=f(k-2), Q[0]=f(k-3).
  - f = u^Q[1]^Q[0], i.e. g0 = 1+D²+D³.
  - Parity = f^Q[2]^Q[0], i.e. g1 = 1+D+D³.
  - Parity and systematic outputs are combinational from the current u and Q; they are meaningful when enc_enable=1.
  - On a clock edge with enable=1: Q <= {f,Q[2],Q[1]}.
  - clr has priority over enable and forces Q to 000 synchronously.
- length_out: the length input registered every cycle, with no enable.
- FSM states (current_state): IDLE=0, ENCODE=1, TERM=2, CLEAR=3.
- IDLE:
  - enc_enable = data_valid.
  - On data_valid: latch K from length, counter <= 1, go to ENCODE.
  - If K==1, go directly to TERM.
- ENCODE:
  - enc_enable = data_valid.
  - data_valid=0 stalls: counter and encoder states hold.
  - On data_valid with counter==K-1: counter <= 0, go to TERM. Otherwise counter increments.
- TERM:
  - trellis_enable = switch = 1; enc_enable = 0; q and p hold.
  - Lasts TAIL_CYCLES cycles, then go to CLEAR.
- CLEAR:
  - One cycle with clr = trl_clr = 1; encoders zeroed.
  - Next state is IDLE.
- data_valid during TERM or CLEAR is ignored; upstream must not assert it there.
- length changes during a block are ignored; K is latched only at block start.
- Reset mid-block aborts the block immediately.

Decomposition:
- Shared package: FSM state codes, K_SMALL/K_LARGE defaults, TAIL_CYCLES.
- One sub-module, rsc_enc: ports clk, rst, clr, enable, u, x, z, Q[2:0]. It is instantiated twice.
- The FSM and the length register stay in the top level.

Test Plan:
- Reset, then rst=1 idle for 3 cycles -> all outputs 0, current_state=0.
- Impulse on encoder 1 from the zero state, with ck = 1,0,0,0 on consecutive valid cycles:
  - zk = 1,1,1,1.
  - q after each step = 100, 010, 101, 110.
- Full block with K_SMALL=4, K_LARGE=6, length=0, and 4 consecutive valid bits:
  - enc_enable high for 4 cycles.
  - current_state goes 1→2 after the 4th bit.
  - trellis_enable and switch high for exactly 4 cycles.
  - Then one cycle with clr=trl_clr=1, q=p=000, then state 0.
- Same setup with length=1 -> ENCODE spans 6 valid bits.
  - length_out follows length one cycle late.
- Stall: drop data_valid for 2 cycles mid-ENCODE -> counter, q and p hold; the block still ends after exactly K valid bits.
- Assert rst=0 asynchronously during TERM -> outputs clear before the next clock edge; state 0.
